// File: rtl/data_memory_responder.sv
// MEM-stage data memory: word RAM with fixed access latency, pipeline stall, byte/half lanes.
// Optional fault detection is enabled by defining DATA_MEMORY_FAULT_EN.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memoryReadEnable,
  input  logic        memoryWriteEnable,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memoryStall,
  output logic        misalignedFault
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, state_next;
  logic [3:0]            count;
  logic [ADDR_WIDTH+1:0] cap_addr;
  logic [2:0]            cap_funct3;
  logic [31:0]           cap_wdata;
  logic                  cap_write;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic                  req, commit;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  legal, misaligned, fault, is_signed;
  logic [1:0]            size, lane;
  logic [31:0]           word, shifted, load_value, mask, wshift, merged;
  logic                  unused_addr;

  assign req         = memoryReadEnable | memoryWriteEnable;
  assign memoryStall = req & (state != DONE) & ~reset;
  assign commit      = (state == WAIT) && (count == '0);
  assign idx         = cap_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^address[31:ADDR_WIDTH+2];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = WAIT;
      WAIT:    if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Illegal funct3 decodes to a full-word access; lane is forced to the
  // containing boundary so the fault-free build performs aligned accesses.
  always_comb begin
    legal      = cap_write ? (cap_funct3 inside {3'b000, 3'b001, 3'b010})
                           : (cap_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    size       = legal ? cap_funct3[1:0] : 2'd2;
    is_signed  = ~cap_funct3[2];
    misaligned = ((size == 2'd1) && cap_addr[0]) || ((size == 2'd2) && (cap_addr[1:0] != 2'b00));
    case (size)
      2'd0:    lane = cap_addr[1:0];
      2'd1:    lane = {cap_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase
`ifdef DATA_MEMORY_FAULT_EN
    fault = ~legal | misaligned;
`else
    fault = 1'b0;
`endif
    word    = mem[idx];
    shifted = word >> {lane, 3'b000};
    case (size)
      2'd0:    load_value = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    load_value = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: load_value = shifted;
    endcase
    case (size)
      2'd0:    mask = 32'h0000_00FF << {lane, 3'b000};
      2'd1:    mask = 32'h0000_FFFF << {lane, 3'b000};
      default: mask = '1;
    endcase
    wshift = cap_wdata << {lane, 3'b000};
    merged = (word & ~mask) | (wshift & mask);
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && cap_write && !fault) mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count           <= '0;
      readData        <= '0;
      misalignedFault <= 1'b0;
      cap_addr        <= '0;
      cap_funct3      <= '0;
      cap_wdata       <= '0;
      cap_write       <= 1'b0;
    end else begin
      misalignedFault <= commit & fault;
      if (state == IDLE && req) begin
        count      <= 4'(LATENCY - 1);
        cap_addr   <= address[ADDR_WIDTH+1:0];
        cap_funct3 <= funct3;
        cap_wdata  <= writeData;
        cap_write  <= memoryWriteEnable;
      end else if (state == WAIT && count != '0) begin
        count <= count - 4'd1;
      end
      if (commit && !cap_write) readData <= fault ? '0 : load_value;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed table-driven bench for data_memory_responder; expectations follow DATA_MEMORY_FAULT_EN.
module tb_data_memory_responder;

`ifdef DATA_MEMORY_FAULT_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        a_re, a_we, a_stall, a_fault;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_re, b_we, b_stall, b_fault;
  logic [2:0]  b_f3;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .memoryReadEnable(a_re), .memoryWriteEnable(a_we),
    .funct3(a_f3), .address(a_addr), .writeData(a_wdata), .readData(a_rdata),
    .memoryStall(a_stall), .misalignedFault(a_fault));

  data_memory_responder #(.ADDR_WIDTH(4), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .memoryReadEnable(b_re), .memoryWriteEnable(b_we),
    .funct3(b_f3), .address(b_addr), .writeData(b_wdata), .readData(b_rdata),
    .memoryStall(b_stall), .misalignedFault(b_fault));

  typedef struct {
    logic        wr, rd;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_rd;
    logic        exp_flt, chk_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic rd, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rd, logic exp_flt, logic chk_rd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_flt = exp_flt; v.chk_rd = chk_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge, holds it while stalled, samples in the DONE cycle.
  task automatic access(input int which, input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic flt, output int ncyc,
                        output logic flt_after);
    logic st;
    @(negedge clk);
    if (which == 0) begin
      a_we = wr; a_re = rd; a_f3 = f3; a_addr = addr; a_wdata = wdata;
    end else begin
      b_we = wr; b_re = rd; b_f3 = f3; b_addr = addr; b_wdata = wdata;
    end
    ncyc = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      st = (which == 0) ? a_stall : b_stall;
      if (!st) break;
      ncyc++;
      @(negedge clk);
    end
    rdata = (which == 0) ? a_rdata : b_rdata;
    flt   = (which == 0) ? a_fault : b_fault;
    if (which == 0) begin a_we = 1'b0; a_re = 1'b0; end
    else            begin b_we = 1'b0; b_re = 1'b0; end
    @(negedge clk);
    #1;
    flt_after = (which == 0) ? a_fault : b_fault;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        flt, flt_after;
    int          ncyc;

    vecs.push_back(mk(1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(1, 0, 3'b000, 32'h13, 32'h00000080, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, 1, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0, 1));
    vecs.push_back(mk(0, 1, 3'b100, 32'h13, 32'h0,        32'h00000080, 0, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0, 1));
    vecs.push_back(mk(0, 1, 3'b001, 32'h11, 32'h0,        FE ? 32'h0 : 32'hFFFFBEEF, FE, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0, 1));
    vecs.push_back(mk(0, 1, 3'b001, 32'h12, 32'h0,        32'hFFFF80AD, 0, 1));
    vecs.push_back(mk(0, 1, 3'b101, 32'h13, 32'h0,        FE ? 32'h0 : 32'h000080AD, FE, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h11, 32'h0,        FE ? 32'h0 : 32'h80ADBEEF, FE, 1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h14, 32'h11223344, 32'h0,        0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h16, 32'hFFFF7777, 32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 3'b101, 32'h16, 32'h0,        32'h00007777, 0, 1));
    vecs.push_back(mk(1, 0, 3'b000, 32'h14, 32'hFFFFFF99, 32'h00007777, 0, 1));
    vecs.push_back(mk(0, 1, 3'b001, 32'h14, 32'h0,        32'h00003399, 0, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h14, 32'h0,        32'h77773399, 0, 1));
    vecs.push_back(mk(1, 0, 3'b011, 32'h14, 32'hCAFEF00D, 32'h0,        FE, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h14, 32'h0,        FE ? 32'h77773399 : 32'hCAFEF00D, 0, 1));
    vecs.push_back(mk(0, 1, 3'b110, 32'h14, 32'h0,        FE ? 32'h0 : 32'hCAFEF00D, FE, 1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h24, 32'h0BADF00D, 32'h0,        0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h26, 32'hAAAA5555, 32'h0,        FE, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h24, 32'h0,        FE ? 32'h0BADF00D : 32'hAAAA5555, 0, 1));
    vecs.push_back(mk(1, 1, 3'b010, 32'h00, 32'h00000005, 32'h0,        0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h00, 32'h0,        32'h00000005, 0, 1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h20, 32'h99887766, 32'h00000005, 0, 1));

    // Reset with a request held high: stall must be masked.
    reset = 1'b1;
    a_re = 1'b1; a_we = 1'b0; a_f3 = 3'b010; a_addr = '0; a_wdata = '0;
    b_re = 1'b1; b_we = 1'b0; b_f3 = 3'b010; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall_a", 32'(a_stall), 32'h0);
    check("reset_rdata_a", a_rdata, 32'h0);
    check("reset_fault_a", 32'(a_fault), 32'h0);
    check("reset_stall_b", 32'(b_stall), 32'h0);
    check("reset_rdata_b", b_rdata, 32'h0);
    a_re = 1'b0; b_re = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      access(0, vecs[i].wr, vecs[i].rd, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             rdata, flt, ncyc, flt_after);
      check($sformatf("vec%0d_stall_cycles", i), 32'(ncyc), 32'd3);
      check($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].exp_flt));
      check($sformatf("vec%0d_fault_after", i), 32'(flt_after), 32'h0);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
    end

    // Reset in the first WAIT cycle of SW 0x12345678 @0x20 discards the store.
    access(0, 0, 1, 3'b010, 32'h20, 32'h0, rdata, flt, ncyc, flt_after);
    check("pre_reset_lw", rdata, 32'h99887766);
    @(negedge clk);
    a_we = 1'b1; a_re = 1'b0; a_f3 = 3'b010; a_addr = 32'h20; a_wdata = 32'h12345678;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_stall", 32'(a_stall), 32'h0);
    @(negedge clk);
    #1;
    check("midreset_rdata", a_rdata, 32'h0);
    check("midreset_fault", 32'(a_fault), 32'h0);
    check("midreset_stall2", 32'(a_stall), 32'h0);
    a_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    access(0, 0, 1, 3'b010, 32'h20, 32'h0, rdata, flt, ncyc, flt_after);
    check("post_reset_lw", rdata, 32'h99887766);
    check("post_reset_stall_cycles", 32'(ncyc), 32'd3);

    // Narrow RAM with minimum latency: 0x40 wraps onto word 0.
    access(1, 1, 0, 3'b010, 32'h40, 32'h000000A5, rdata, flt, ncyc, flt_after);
    check("wrap_sw_stall_cycles", 32'(ncyc), 32'd2);
    access(1, 0, 1, 3'b010, 32'h00, 32'h0, rdata, flt, ncyc, flt_after);
    check("wrap_lw_rdata", rdata, 32'h000000A5);
    check("wrap_lw_stall_cycles", 32'(ncyc), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
